// File: rtl/reg_share_arbiter_if.sv
// Handshake bundle between two write requesters, a preset source
// and the shared-register arbiter.
interface reg_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             preset_req;
    logic             gnt0;
    logic             gnt1;
    logic             ack0;
    logic             ack1;
    logic             preset_ack;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic [7:0]       wr_count;

    modport master (
        output req0, req1, data0, data1, preset_req,
        input  gnt0, gnt1, ack0, ack1, preset_ack,
        input  q, busy, wr_count
    );

    modport slave (
        input  req0, req1, data0, data1, preset_req,
        output gnt0, gnt1, ack0, ack1, preset_ack,
        output q, busy, wr_count
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter owning one shared register with a preset path.
// Every output is driven straight from a flop.
module reg_share_arbiter #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    reg_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        PRE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             pack_q, pack_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             win_q, win_d;
    logic             pick;

    // On contention the requester that did not win last time goes next.
    assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        pack_d  = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE: begin
                if (bus.preset_req) begin
                    state_d = PRE;
                    q_d     = PRESET_VAL;
                    pack_d  = 1'b1;
                end else if (bus.req0 || bus.req1) begin
                    state_d = LOAD;
                    win_d   = pick;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                end
            end
            LOAD: begin
                state_d = DONE;
                q_d     = win_q ? bus.data1 : bus.data0;
                ack0_d  = ~win_q;
                ack1_d  = win_q;
            end
            DONE: begin
                state_d = IDLE;
                last_d  = win_q;
                cnt_d   = cnt_q + 8'd1;
            end
            PRE: begin
                state_d = IDLE;
                cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= PRESET_VAL;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            pack_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            pack_q  <= pack_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.preset_ack = pack_q;
    assign bus.busy       = busy_q;
    assign bus.wr_count   = cnt_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: reset, single write, contention,
// preset priority, reset abort and counter wrap.
module tb_reg_share_arbiter;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    reg_share_arbiter_if #(.WIDTH(W)) bus ();

    reg_share_arbiter #(
        .WIDTH(W),
        .PRESET_VAL(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if (!$onehot0({bus.gnt0, bus.gnt1, bus.ack0,
                       bus.ack1, bus.preset_ack})) begin
            errors++;
            $display("FAIL onehot at %0t: got %b need onehot0", $time,
                     {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.preset_ack});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req0       = 1'b0;
        bus.req1       = 1'b0;
        bus.data0      = '0;
        bus.data1      = '0;
        bus.preset_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        step();
        checks++;
        if (bus.q !== 8'hFF) begin
            errors++;
            $display("FAIL reset_q got %h need ff", bus.q);
        end
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1,
             bus.preset_ack, bus.busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs got %b need 000000",
                     {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1,
                      bus.preset_ack, bus.busy});
        end
        checks++;
        if (bus.wr_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d need 0", bus.wr_count);
        end
    endtask

    task automatic test_single();
        bus.data0 = 8'h3C;
        bus.req0  = 1'b1;
        step();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101 || bus.q !== 8'hFF) begin
            errors++;
            $display("FAIL single_gnt got g%b b%b q%h need g10 b1 qff",
                     {bus.gnt0, bus.gnt1}, bus.busy, bus.q);
        end
        step();
        checks++;
        if (bus.q !== 8'h3C || bus.ack0 !== 1'b1 || bus.gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got q%h a%b g%b need q3c a1 g0",
                     bus.q, bus.ack0, bus.gnt0);
        end
        bus.req0 = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.wr_count !== 8'd1) begin
            errors++;
            $display("FAIL single_done got b%b a%b c%0d need b0 a0 c1",
                     bus.busy, bus.ack0, bus.wr_count);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_q;
        do_reset();
        bus.data0 = 8'h11;
        bus.data1 = 8'h22;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q = (k % 2 == 0) ? 8'h11 : 8'h22;
            step();
            checks++;
            if (bus.gnt0 !== (k % 2 == 0) || bus.gnt1 !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_gnt%0d got %b%b need %b%b", k,
                         bus.gnt0, bus.gnt1, k % 2 == 0, k % 2 == 1);
            end
            step();
            checks++;
            if (bus.q !== exp_q || bus.ack0 !== (k % 2 == 0) ||
                bus.ack1 !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_ack%0d got q%h a%b%b need q%h", k,
                         bus.q, bus.ack0, bus.ack1, exp_q);
            end
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            step();
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle%0d got busy %b need 0", k, bus.busy);
            end
        end
        checks++;
        if (bus.q !== 8'h22 || bus.wr_count !== 8'd4) begin
            errors++;
            $display("FAIL rr_end got q%h c%0d need q22 c4",
                     bus.q, bus.wr_count);
        end
    endtask

    task automatic test_preset();
        bus.data1      = 8'h05;
        bus.req1       = 1'b1;
        bus.preset_req = 1'b1;
        step();
        checks++;
        if (bus.preset_ack !== 1'b1 || bus.q !== 8'hFF || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL pre_ack got p%b q%h g%b need p1 qff g0",
                     bus.preset_ack, bus.q, bus.gnt1);
        end
        bus.preset_req = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.wr_count !== 8'd5) begin
            errors++;
            $display("FAIL pre_done got b%b c%0d need b0 c5",
                     bus.busy, bus.wr_count);
        end
        step();
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL pre_gnt1 got %b need 1", bus.gnt1);
        end
        step();
        checks++;
        if (bus.ack1 !== 1'b1 || bus.q !== 8'h05) begin
            errors++;
            $display("FAIL pre_wr got a%b q%h need a1 q05", bus.ack1, bus.q);
        end
        bus.req1 = 1'b0;
        step();
        checks++;
        if (bus.wr_count !== 8'd6 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL pre_cnt got c%0d b%b need c6 b0",
                     bus.wr_count, bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        bus.data1 = 8'hA0;
        bus.req1  = 1'b1;
        step();
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_gnt got %b need 1", bus.gnt1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.ack1 !== 1'b0 || bus.q !== 8'hFF || bus.busy !== 1'b0 ||
            bus.gnt1 !== 1'b0 || bus.wr_count !== 8'd0) begin
            errors++;
            $display("FAIL abort_rst got a%b q%h b%b g%b c%0d need a0 qff b0 g0 c0",
                     bus.ack1, bus.q, bus.busy, bus.gnt1, bus.wr_count);
        end
        step();
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_regnt got %b need 1", bus.gnt1);
        end
        step();
        checks++;
        if (bus.ack1 !== 1'b1 || bus.q !== 8'hA0) begin
            errors++;
            $display("FAIL abort_wr got a%b q%h need a1 qa0", bus.ack1, bus.q);
        end
        bus.req1 = 1'b0;
        step();
        checks++;
        if (bus.wr_count !== 8'd1) begin
            errors++;
            $display("FAIL abort_cnt got %0d need 1", bus.wr_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            bus.data0 = 8'(i);
            bus.req0  = 1'b1;
            step();
            step();
            checks++;
            if (bus.ack0 !== 1'b1 || bus.q !== 8'(i)) begin
                errors++;
                $display("FAIL wrap_wr%0d got a%b q%h need a1 q%h",
                         i, bus.ack0, bus.q, 8'(i));
            end
            bus.req0 = 1'b0;
            step();
            if (i == 254) begin
                checks++;
                if (bus.wr_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255 got %0d need 255", bus.wr_count);
                end
            end
        end
        checks++;
        if (bus.wr_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0 got %0d need 0", bus.wr_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_preset();
        test_reset_abort();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of the shared register and both data inputs.
REQ-002 Parameter PRESET_VAL, default {WIDTH{1'b1}}: value loaded by reset and by a preset command.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  requester 0 write request, level; held until ack0.
REQ-006 req1  input  1  requester 1 write request, level; held until ack1.
REQ-007 data0  input  WIDTH  requester 0 write data; stable while req0 high.
REQ-008 data1  input  WIDTH  requester 1 write data; stable while req1 high.
REQ-009 preset_req  input  1  preset command, level; held until preset_ack.
REQ-010 gnt0, gnt1  output  1 each  grant, registered, one-hot or zero.
REQ-011 ack0, ack1  output  1 each  write-complete pulse, registered.
REQ-012 preset_ack  output  1  preset-complete pulse, registered.
REQ-013 q  output  WIDTH  shared register contents, registered.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 wr_count  output  8  count of completed writes and presets, wraps 255->0.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, DONE, PRE; all outputs SHALL come from flops.
REQ-017 In IDLE with preset_req high: next state PRE, q <= PRESET_VAL at that edge, regardless of req0/req1.
REQ-018 In IDLE, preset_req low, at least one req high: winner chosen, gnt_winner <= 1, next state LOAD.
REQ-019 Arbitration: single requester wins; both high -> requester other than last_winner wins (round-robin).
REQ-020 LOAD (one cycle, gnt high): at its closing edge q <= data_winner, gnt <= 0, ack_winner <= 1, next DONE.
REQ-021 DONE (one cycle, ack high): at closing edge ack <= 0, last_winner <= winner, wr_count += 1, next IDLE.
REQ-022 PRE (one cycle, preset_ack high): at closing edge preset_ack <= 0, wr_count += 1, next IDLE.
REQ-023 Latency: req seen in IDLE cycle N -> gnt in N+1, q updated and ack high in N+2, IDLE in N+3.
REQ-024 Requesters SHALL drop req the cycle after ack; req still high in IDLE is a new request.
REQ-025 preset_req or req arriving outside IDLE SHALL wait; no request is dropped or merged.
REQ-026 Sustained contention: grants alternate 0,1,0,1...; max wait for either requester is one write (3 cycles) plus any pending presets.
REQ-027 No state: at most one of gnt0, gnt1, ack0, ack1, preset_ack high in any cycle.
REQ-028 q SHALL change only at the LOAD closing edge, on PRE entry, or on reset.

Reset
REQ-029 rst high at an edge: state IDLE, q = PRESET_VAL, gnt/ack/preset_ack = 0, busy = 0, wr_count = 0, last_winner = 1.
REQ-030 rst overrides all inputs; reset during LOAD/DONE/PRE aborts: no ack issued, no count increment; q = PRESET_VAL.
REQ-031 First post-reset contention SHALL be won by requester 0.

Verification
REQ-032 Reset then idle: q = 0xFF, all outputs 0, wr_count = 0.
REQ-033 req0=1, data0=0x3C in cycle N: gnt0 at N+1, q = 0x3C and ack0 at N+2, busy low at N+3, wr_count = 1.
REQ-034 req0, req1 high together, held through four writes (data 0x11/0x22): order 0,1,0,1; q ends 0x22; wr_count = 4.
REQ-035 preset_req and req1 (data1=0x05) raised together in IDLE: preset first (q = 0xFF, preset_ack), then req1 write (q = 0x05).
REQ-036 rst asserted during LOAD of req1 (data1=0xA0): no ack1, q = 0xFF, state IDLE; req1 held -> re-served, q = 0xA0.
REQ-037 256 back-to-back req0 writes: wr_count wraps to 0; no grant overlap at any cycle.
